gray_counter: RTL
=================

Name: gray_counter

Overview:
- Parametrised up/down counter that exposes its count in both binary and reflected-Gray form.
- Supports synchronous load from either a binary or a Gray-coded value, wrap or saturate mode, and terminal-count/wrap flags.
- Generalises the fixed 8-bit binary-to-Gray converter with width, direction, load and registered state.
- Feeds clock-domain-crossing pointers (FIFO read/write pointers) and rotary/position logic elsewhere in the design.

Parameters:
- WIDTH, 8: counter width in bits; legal for WIDTH >= 2.
- INIT, 0: binary reset value of the count; must satisfy INIT < 2**WIDTH.
- WRAP, 1: 1 = wrap around at either end; 0 = saturate at 2**WIDTH-1 (up) or 0 (down).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per clk while high.
- up  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_is_gray  input  1  1 = load_val is Gray-coded; 0 = load_val is binary.
- load_val  input  WIDTH  value to load.
- binary  output  WIDTH  registered count, binary.
- gray  output  WIDTH  registered count, Gray code.
- tc  output  1  terminal count, combinational from registered state.
- wrapped  output  1  registered one-cycle pulse; count crossed an end.

Behaviour:
- Reset is asynchronous and active-high. While rst is high, with no clock edge required:
  - binary = INIT
  - gray = INIT ^ (INIT >> 1)
  - wrapped = 0
- State register:
  - Internal binary count cnt; binary = cnt.
  - gray is a separate register loaded with next_cnt ^ (next_cnt >> 1) on the same edge as cnt.
  - This makes gray glitch-free and suitable for synchronisers.
- Latency: load and en are sampled on a rising clk; the result appears on binary and gray after that edge (1 cycle).
- Priority at each edge: load > en > hold.
- load = 1:
  - load_is_gray = 0: cnt <= load_val.
  - load_is_gray = 1: cnt <= gray2bin(load_val), where b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i] for i descending.
  - wrapped <= 0. en is ignored that cycle.
- en = 1, load = 0, up = 1:
  - cnt < max: cnt <= cnt + 1.
  - cnt == max with WRAP = 1: cnt <= 0, wrapped <= 1.
  - cnt == max with WRAP = 0: hold, wrapped <= 0.
- en = 1, load = 0, up = 0:
  - cnt > 0: cnt <= cnt - 1.
  - cnt == 0 with WRAP = 1: cnt <= max, wrapped <= 1.
  - cnt == 0 with WRAP = 0: hold, wrapped <= 0.
- en = 0 and load = 0: hold; wrapped <= 0.
- wrapped is high for exactly one cycle per crossing. It is 0 on any cycle without a crossing, including a held or saturated cycle.
- tc = (up && cnt == max) || (!up && cnt == 0). It reflects direction combinationally, so it follows a change of up within the same cycle.
- Width rules:
  - max = 2**WIDTH - 1.
  - All arithmetic is modulo 2**WIDTH; there are no wider intermediates on the outputs.
- Gray invariant: consecutive gray values produced by counting (not loading) differ in exactly one bit, including across the wrap.
- A direction change mid-sequence takes effect on the next enabled edge with no extra latency.
- Reset asserted mid-count overrides everything immediately. On deassertion, counting resumes from INIT at the first enabled edge.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(WIDTH), a shift-XOR.
  - function gray2bin(WIDTH), the prefix XOR.
  - Constants for default WIDTH and WRAP/SATURATE mode encodings.
- One natural sub-module, gray2bin_comb: purely combinational, parametrised WIDTH, used on the load path.
  - It is reusable by the future CDC pointer-compare logic.
- bin2gray is a one-liner and stays inline via the package function.

Test Plan:
All cases use WIDTH = 4 and INIT = 0 unless stated otherwise.
1. Reset and hold: assert rst for 2 cycles without a clock edge → binary = 0, gray = 0, wrapped = 0 immediately. Then en = 0 for 5 cycles → values unchanged.
2. Up-count with wrap (WRAP = 1, up = 1, en = 1 for 17 cycles):
   - gray sequence is 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
   - tc = 1 only while binary = F.
   - wrapped pulses once on the F→0 edge.
   - Every step is a single-bit gray change.
3. Gray load: load = 1, load_is_gray = 1, load_val = 4'hC → next cycle binary = 8, gray = C. Repeat with load_is_gray = 0, load_val = 4'h5 → binary = 5, gray = 7.
4. Down wrap: from binary = 0, up = 0, en = 1 → binary = F, gray = 8, wrapped = 1 for one cycle. Then binary = E, gray = 9, wrapped = 0.
5. Saturation (WRAP = 0): load F, then up = 1, en = 1 for 3 cycles → binary stays F, tc = 1, wrapped = 0. Flip up = 0 → tc = 0 in the same cycle; next edge binary = E.
6. Priority and async reset:
   - load = 1 (load_val = 3) with en = 1 in the same cycle → binary = 3, not 4.
   - Assert rst mid-count between clock edges → outputs return to INIT immediately.
   - With INIT = 5: reset gives binary = 5, gray = 7.

Source files
------------

// File: rtl/gray_pkg.sv
// ============================================================================
// Module      : gray_pkg
// Description : Shared Gray-code helpers and counter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

    localparam int C_DEFAULT_WIDTH = 8;
    localparam int C_MAX_WIDTH     = 64;
    localparam int C_MODE_SATURATE = 0;
    localparam int C_MODE_WRAP     = 1;

    // Operands are zero-extended to C_MAX_WIDTH; callers cast the result back.
    function automatic logic [C_MAX_WIDTH-1:0] bin2gray(input logic [C_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [C_MAX_WIDTH-1:0] gray2bin(input logic [C_MAX_WIDTH-1:0] g);
        logic [C_MAX_WIDTH-1:0] b;
        b[C_MAX_WIDTH-1] = g[C_MAX_WIDTH-1];
        for (int i = C_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin_comb.sv
// ============================================================================
// Module      : gray2bin_comb
// Description : Combinational reflected-Gray to binary converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_binary
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        assign o_binary[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/gray_counter.sv
// ============================================================================
// Module      : gray_counter
// Description : Up/down counter with registered binary and Gray outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int INIT  = 0,
    parameter int WRAP  = C_MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] c_init      = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] c_init_gray = c_init ^ (c_init >> 1);
    localparam logic [WIDTH-1:0] c_max       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_one       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_bin;
    logic             w_wrap;
    logic             w_at_max;
    logic             w_at_zero;

    gray2bin_comb #(
        .WIDTH    (WIDTH)
    ) u_load_g2b (
        .i_gray   (load_val),
        .o_binary (w_load_bin)
    );

    assign w_at_max  = (r_cnt == c_max);
    assign w_at_zero = (r_cnt == c_zero);

    always_comb begin
        w_next = r_cnt;
        w_wrap = 1'b0;
        if (load) begin
            w_next = load_is_gray ? w_load_bin : load_val;
        end else if (en) begin
            if (up) begin
                if (!w_at_max) begin
                    w_next = r_cnt + c_one;
                end else if (WRAP == C_MODE_WRAP) begin
                    w_next = c_zero;
                    w_wrap = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_next = r_cnt - c_one;
                end else if (WRAP == C_MODE_WRAP) begin
                    w_next = c_max;
                    w_wrap = 1'b1;
                end
            end
        end
    end

    // Gray is its own register so the synchroniser sees single-bit transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= c_init;
            r_gray    <= c_init_gray;
            r_wrapped <= 1'b0;
        end else begin
            r_cnt     <= w_next;
            r_gray    <= WIDTH'(bin2gray(C_MAX_WIDTH'(w_next)));
            r_wrapped <= w_wrap;
        end
    end

    assign binary  = r_cnt;
    assign gray    = r_gray;
    assign wrapped = r_wrapped;
    assign tc      = up ? w_at_max : w_at_zero;

endmodule

`default_nettype wire
